clk_edge_monitor: RTL and testbench

Clock-domain receiver for slow, divided or external clocks such as the camera XCLK/PCLK pair. It samples the slow clock as an asynchronous data signal in the fast system clock domain and emits single-cycle rise/fall strobes. It also measures the slow clock's period in system cycles and reports frequency lock and signal loss. Downstream capture logic uses the strobes as clock enables instead of clocking flops from the slow clock directly.

---
 rtl/clk_edge_monitor_if.sv | 27 ++
 rtl/clk_edge_monitor.sv | 158 +++++++++++++++
 tb/tb_clk_edge_monitor.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/clk_edge_monitor_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clk_edge_monitor_if : slow-clock input and edge/period/lock outputs      |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface clk_edge_monitor_if #(
    parameter int CNT_W = 16
);
    logic             i_sclk;
    logic             o_rise;
    logic             o_fall;
    logic [CNT_W-1:0] o_period;
    logic             o_period_valid;
    logic             o_locked;
    logic             o_lost;

    modport master (
        output i_sclk,
        input  o_rise, o_fall, o_period, o_period_valid, o_locked, o_lost
    );

    modport slave (
        input  i_sclk,
        output o_rise, o_fall, o_period, o_period_valid, o_locked, o_lost
    );
endinterface
`default_nettype wire

// File: rtl/clk_edge_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clk_edge_monitor : edge strobes, period measurement, lock/loss detection |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module clk_edge_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int LOCK_COUNT  = 4,
    parameter int TOLERANCE   = 1,
    parameter int TIMEOUT     = 1024
) (
    input  wire logic         clk,
    input  wire logic         rst,
    clk_edge_monitor_if.slave bus
);

    localparam int                 C_MATCH_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0]   C_TIMEOUT    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]   C_TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W:0]     C_TOL        = (CNT_W + 1)'(TOLERANCE);
    localparam logic [C_MATCH_W-1:0] C_LOCK     = C_MATCH_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    state_t                 state_q, state_d;
    logic [C_MATCH_W-1:0]   match_q, match_d;
    logic                   first_q, first_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   locked_q, locked_d;
    logic                   lost_q, lost_d;

    logic                   w_sync_out;
    logic                   w_rise;
    logic                   w_timeout;
    logic [CNT_W:0]         w_new_period;
    logic [CNT_W:0]         w_prev_period;
    logic [CNT_W:0]         w_diff;
    logic                   w_hit;
    logic [C_MATCH_W-1:0]   w_match_inc;

    always_comb begin
        w_sync_out = sync_q[SYNC_STAGES-1];
        sync_d     = {sync_q[SYNC_STAGES-2:0], bus.i_sclk};
        prev_d     = w_sync_out;
        w_rise     = w_sync_out & ~prev_q;
        rise_d     = w_rise;
        fall_d     = ~w_sync_out & prev_q;

        if (w_rise) begin
            cnt_d = '0;
        end else if (cnt_q == C_TIMEOUT) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        // Loss fires only on the edge the counter first reaches TIMEOUT.
        w_timeout = ~w_rise && (cnt_q == C_TIMEOUT_M1);

        // Unsigned distance on CNT_W+1 bits so the difference never wraps.
        w_new_period  = {1'b0, cnt_q} + 1'b1;
        w_prev_period = {1'b0, period_q};
        w_diff        = (w_new_period >= w_prev_period) ? (w_new_period - w_prev_period)
                                                        : (w_prev_period - w_new_period);
        w_hit         = ~first_q && (w_diff <= C_TOL);
        w_match_inc   = (match_q == C_LOCK) ? match_q : match_q + 1'b1;

        state_d  = state_q;
        match_d  = match_q;
        first_d  = first_q;
        period_d = period_q;
        valid_d  = 1'b0;
        lost_d   = lost_q;

        if (w_rise) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_MEASURE;
                    first_d = 1'b1;
                    match_d = '0;
                    lost_d  = 1'b0;
                end
                ST_MEASURE, ST_LOCKED: begin
                    period_d = w_new_period[CNT_W-1:0];
                    valid_d  = 1'b1;
                    first_d  = 1'b0;
                    match_d  = w_hit ? w_match_inc : '0;
                    if (state_q == ST_MEASURE) begin
                        if (w_hit && (w_match_inc == C_LOCK)) begin
                            state_d = ST_LOCKED;
                        end
                    end else if (!w_hit) begin
                        state_d = ST_MEASURE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    match_d = '0;
                end
            endcase
        end else if (w_timeout) begin
            state_d = ST_IDLE;
            match_d = '0;
            lost_d  = 1'b1;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            prev_q   <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            cnt_q    <= '0;
            state_q  <= ST_IDLE;
            match_q  <= '0;
            first_q  <= 1'b0;
            period_q <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            prev_q   <= prev_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            match_q  <= match_d;
            first_q  <= first_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            lost_q   <= lost_d;
        end
    end

    assign bus.o_rise         = rise_q;
    assign bus.o_fall         = fall_q;
    assign bus.o_period       = period_q;
    assign bus.o_period_valid = valid_q;
    assign bus.o_locked       = locked_q;
    assign bus.o_lost         = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_edge_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_clk_edge_monitor : directed bench with per-rise expectation queue     |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_clk_edge_monitor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    clk_edge_monitor_if ifc0 ();
    clk_edge_monitor_if ifc1 ();
    assign ifc1.i_sclk = ifc0.i_sclk;

    clk_edge_monitor #(.TOLERANCE(1)) u_dut_tol1 (.clk(clk), .rst(rst), .bus(ifc0));
    clk_edge_monitor #(.TOLERANCE(0)) u_dut_tol0 (.clk(clk), .rst(rst), .bus(ifc1));

    typedef struct {
        bit valid;
        int period;
        bit locked;
        bit lost;
    } exp_t;

    exp_t sb[$];
    exp_t e_pop;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int fall_seen = 0;
    int falls_driven = 0;
    bit rise_prev = 1'b0;
    bit jit = 1'b0;

    // Reference model, advanced once per driven rising edge
    bit m_idle = 1'b1;
    bit m_first = 1'b0;
    bit m_locked = 1'b0;
    int m_match = 0;
    int m_prev = 0;
    int last_drive = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic void push_rise();
        exp_t e;
        int p;
        bit hit;
        int d;
        p = cyc - last_drive;
        last_drive = cyc;
        if (m_idle) begin
            m_idle = 1'b0;
            m_first = 1'b1;
            m_locked = 1'b0;
            m_match = 0;
            e = '{valid: 1'b0, period: 0, locked: 1'b0, lost: 1'b0};
        end else begin
            d = (p > m_prev) ? p - m_prev : m_prev - p;
            hit = !m_first && (d <= 1);
            m_first = 1'b0;
            m_match = hit ? ((m_match >= 4) ? 4 : m_match + 1) : 0;
            if (m_locked && !hit) m_locked = 1'b0;
            else if (!m_locked && m_match >= 4) m_locked = 1'b1;
            m_prev = p;
            e = '{valid: 1'b1, period: p, locked: m_locked, lost: 1'b0};
        end
        sb.push_back(e);
    endfunction

    function automatic void model_to_idle();
        m_idle = 1'b1;
        m_first = 1'b0;
        m_locked = 1'b0;
        m_match = 0;
    endfunction

    // Entered and left at 1ns after a rising clk edge
    task automatic drive_cycle(input int h, input int l);
        ifc0.i_sclk = 1'b1;
        push_rise();
        repeat (h) @(posedge clk);
        #1;
        ifc0.i_sclk = 1'b0;
        falls_driven++;
        repeat (l) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ifc0.o_fall) fall_seen++;
            if (ifc0.o_rise) begin
                chk("rise_width", rise_prev, 0);
                if (sb.size() == 0) begin
                    chk("unexpected_rise", ifc0.o_rise, 0);
                end else begin
                    e_pop = sb.pop_front();
                    chk("period_valid", ifc0.o_period_valid, e_pop.valid);
                    if (e_pop.valid) begin
                        chk("period", ifc0.o_period, e_pop.period);
                        chk("rise_spacing", cyc - last_rise_cyc, e_pop.period);
                    end
                    chk("locked", ifc0.o_locked, e_pop.locked);
                    chk("lost", ifc0.o_lost, e_pop.lost);
                end
                last_rise_cyc = cyc;
            end else begin
                chk("valid_without_rise", ifc0.o_period_valid, 0);
            end
            if (jit && ifc1.o_rise) chk("tol0_locked", ifc1.o_locked, 0);
            rise_prev = ifc0.o_rise;
        end else begin
            rise_prev = 1'b0;
        end
    end

    initial begin
        int k;
        ifc0.i_sclk = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rise", ifc0.o_rise, 0);
        chk("rst_fall", ifc0.o_fall, 0);
        chk("rst_period", ifc0.o_period, 0);
        chk("rst_valid", ifc0.o_period_valid, 0);
        chk("rst_locked", ifc0.o_locked, 0);
        chk("rst_lost", ifc0.o_lost, 0);
        rst = 1'b0;
        last_drive = cyc;

        // Period 8: lock with the 6th rise
        repeat (10) drive_cycle(4, 4);
        chk("p8_locked", ifc0.o_locked, 1);
        chk("p8_period", ifc0.o_period, 8);
        chk("fall_count", fall_seen, falls_driven);

        // Frequency step to period 12
        repeat (8) drive_cycle(6, 6);
        chk("p12_locked", ifc0.o_locked, 1);
        chk("p12_period", ifc0.o_period, 12);

        // Jitter 8/9: tolerant instance stays locked, exact instance never locks
        repeat (2) drive_cycle(4, 4);
        jit = 1'b1;
        for (int i = 0; i < 16; i++) drive_cycle(4, (i % 2 == 1) ? 5 : 4);
        jit = 1'b0;
        chk("jitter_locked", ifc0.o_locked, 1);
        chk("jitter_tol0_unlocked", ifc1.o_locked, 0);

        // Stop the slow clock while locked
        for (k = 0; k < 1100; k++) begin
            @(posedge clk);
            #1;
            if (ifc0.o_lost) break;
        end
        chk("lost_seen", ifc0.o_lost, 1);
        chk("lost_delay", cyc - last_rise_cyc, 1024);
        chk("lost_unlocked", ifc0.o_locked, 0);
        model_to_idle();
        last_drive = cyc;
        repeat (8) drive_cycle(4, 4);
        chk("restart_lost_clear", ifc0.o_lost, 0);
        chk("restart_locked", ifc0.o_locked, 1);

        // Asynchronous reset in the middle of a period
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_rise", ifc0.o_rise, 0);
        chk("arst_period", ifc0.o_period, 0);
        chk("arst_valid", ifc0.o_period_valid, 0);
        chk("arst_locked", ifc0.o_locked, 0);
        chk("arst_lost", ifc0.o_lost, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_to_idle();
        last_drive = cyc;
        repeat (5) drive_cycle(4, 4);
        chk("relock_not_yet", ifc0.o_locked, 0);
        drive_cycle(4, 4);
        chk("relock", ifc0.o_locked, 1);

        repeat (6) @(posedge clk);
        #1;
        chk("queue_empty", sb.size(), 0);
        chk("fall_count_end", fall_seen, falls_driven);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
